// File: rtl/booth2_issue_ctrl.sv
// Operand FIFO, one-at-a-time issue to the booth2 sequential multiplier, in-order result stream.
// Optional macro BOOTH2_ZERO_BYPASS_EN: ops with a zero operand complete without a multiply.
module booth2_issue_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  output logic        mul_start,
  output logic [15:0] mul_x,
  output logic [15:0] mul_y,
  input  logic        mul_busy,
  input  logic [31:0] mul_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic [15:0] out_x,
  output logic [15:0] out_y,
  output logic        out_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

`ifdef BOOTH2_ZERO_BYPASS_EN
  localparam bit ZERO_BYPASS = 1'b1;
`else
  localparam bit ZERO_BYPASS = 1'b0;
`endif

  logic [15:0]   mem_x [DEPTH];
  logic [15:0]   mem_y [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [15:0]   head_x;
  logic [15:0]   head_y;
  logic [2:0]    state;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = ~full;
  assign push      = in_valid & ~full;
  assign pop       = (state == S_IDLE) & ~empty & ~out_valid;
  assign head_x    = mem_x[rd_ptr[AW-1:0]];
  assign head_y    = mem_y[rd_ptr[AW-1:0]];
  assign mul_start = (state == S_START);
  assign tmo_hit   = (tmo_cnt >= CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr[AW-1:0]] <= in_x;
      mem_y[wr_ptr[AW-1:0]] <= in_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      mul_x     <= '0;
      mul_y     <= '0;
      out_valid <= 1'b0;
      out_z     <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            mul_x <= head_x;
            mul_y <= head_y;
            if (ZERO_BYPASS && (head_x == '0 || head_y == '0)) begin
              out_z     <= '0;
              out_err   <= 1'b0;
              out_x     <= head_x;
              out_y     <= head_y;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_START;
            end
          end
        end
        S_START: begin
          tmo_cnt <= '0;
          state   <= S_WAIT_BUSY;
        end
        // WAIT_BUSY and RUN share one timeout counter; completion wins over timeout, timeout over WAIT->RUN.
        S_WAIT_BUSY, S_RUN: begin
          if (state == S_RUN && !mul_busy) begin
            out_z     <= mul_z;
            out_err   <= 1'b0;
            out_x     <= mul_x;
            out_y     <= mul_y;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else if (tmo_hit) begin
            out_z     <= '0;
            out_err   <= 1'b1;
            out_x     <= mul_x;
            out_y     <= mul_y;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (mul_busy) state <= S_RUN;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/booth2_issue_ctrl.md
Name: booth2_issue_ctrl

Overview:
- Operand-issue and result-collect stage wrapped around the booth2 sequential 16x16 signed multiplier.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Launches one multiply at a time using a single-cycle start pulse, then captures z when the multiplier's busy flag falls.
- Presents each product on a valid/ready output stream, in order, with an error flag when the multiplier times out.

Parameters:
DEPTH, 4, operand FIFO entries; power of two, 2..16
TIMEOUT, 32, max cycles from mul_start to busy falling before the op is aborted with out_err=1

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  FIFO not full
in_x  input  16  signed multiplicand
in_y  input  16  signed multiplier
mul_start  output  1  one-cycle start pulse to booth2
mul_x  output  16  operand x to booth2
mul_y  output  16  operand y to booth2
mul_busy  input  1  booth2 busy
mul_z  input  32  booth2 product
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_z  output  32  signed product
out_x  output  16  echo of x for this result
out_y  output  16  echo of y for this result
out_err  output  1  result aborted by timeout; out_z=0

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset: FIFO empty, FSM in IDLE. All outputs are 0 except in_ready=1.
  - Reset mid-operation drops the in-flight op and all buffered ops.
  - mul_start stays 0 in the cycle after reset.
- FIFO:
  - Write when in_valid&in_ready.
  - Read (pop) on the IDLE->START transition.
  - in_ready = ~full.
  - Simultaneous push and pop while full is not allowed; in_ready is already 0.
  - Simultaneous push and pop at any other occupancy is legal; the count is unchanged.
  - Pointers wrap modulo DEPTH, with an extra wrap bit for full/empty.
- FSM states:
  - IDLE: if the FIFO is non-empty and out_valid=0, pop the head into the mul_x/mul_y registers and go to START.
  - START: mul_start=1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY: mul_busy=1 -> RUN.
  - RUN: mul_busy=0 -> capture mul_z into out_z, set out_err=0, go to DONE.
  - Timeout, checked in WAIT_BUSY and RUN: the counter reaches TIMEOUT -> out_z=0, out_err=1, go to DONE.
  - DONE: out_valid=1. When out_ready=1, go to IDLE; out_valid drops the next cycle.
- Holding rules:
  - mul_x/mul_y are held stable from START until the FSM returns to IDLE.
  - out_z/out_x/out_y/out_err are held while out_valid=1 and out_ready=0.
- Throughput and latency:
  - One op in flight at a time.
  - Minimum in_valid-to-out_valid latency: 1 (FIFO write) + 1 (IDLE) + 1 (START) + booth2 latency + 1 (capture).
  - Back-to-back ops: the next START occurs no earlier than the cycle after the out handshake.
- Results are produced in input order; no reordering.
- mul_busy high while in IDLE, START-cycle excepted, is ignored.

Optional Feature:
- Macro: BOOTH2_ZERO_BYPASS_EN.
- Defined: in IDLE, if the popped head has x==0 or y==0, skip START, WAIT_BUSY and RUN.
  - Go directly to DONE with out_z=0, out_err=0.
  - mul_start is not pulsed for that op.
- Undefined: every op, including zero operands, goes through booth2.

Test Plan:
- Single op: push x=0x0006, y=0x0005, bench booth2 model busy for 8 cycles -> exactly one mul_start pulse; out_valid with out_z=0x0000001e, out_err=0.
- Stream of 4 ops back-to-back, with out_ready=1 and in_valid held high:
  - Ops: 0xfffa*0x0005, 0x1234*0x1234, 0xf100*0xf789, 0x8001*0x6578.
  - Required outputs in order: 0xffffffe2, 0x014B5A90, 0x007EF900, 0xCD446578.
  - in_ready drops only when 4 entries are buffered.
- Backpressure: out_ready=0 for 20 cycles after the first result -> out_z held stable, no new mul_start; releasing out_ready pops the next op.
- Timeout: the model never asserts busy for x=0x0589, y=0xc643 -> out_valid after TIMEOUT cycles with out_err=1, out_z=0. The next op 0x0589*0xc643 with a good model -> 0xFEC068DB.
- Zero bypass with x=0x0000, y=0xff21 -> out_z=0x00000000:
  - With BOOTH2_ZERO_BYPASS_EN: no mul_start pulse.
  - Without BOOTH2_ZERO_BYPASS_EN: one mul_start pulse.
- Reset mid-RUN: assert rst for 1 cycle while busy=1 with 3 ops queued -> in_ready=1, out_valid=0, FIFO empty. The next push 0x7658*0x0000 yields 0x00000000 normally.
